// File: rtl/xalu_ise_pkg.sv
// Shared constants and types for the Xoodyak ISE ALU.
package xalu_ise_pkg;

    // Custom-opcode selectors (ise_fn[1:0])
    localparam logic [1:0] CUSTOM_0 = 2'b00;
    localparam logic [1:0] CUSTOM_1 = 2'b01;
    localparam logic [1:0] CUSTOM_2 = 2'b10;
    localparam logic [1:0] CUSTOM_3 = 2'b11;

    // funct7 codes under CUSTOM_1
    localparam logic [6:0] FN_XORROL = 7'b0100000;
    localparam logic [6:0] FN_ANDN   = 7'b0100001;
    localparam logic [6:0] FN_ROLV   = 7'b0100010;

    // Fixed rotate amounts of the XORROL primitive
    localparam logic [4:0] ROT_A = 5'd5;
    localparam logic [4:0] ROT_B = 5'd14;

    // One-hot op; all-zero means "not an ISE op"
    typedef struct packed {
        logic rolv;
        logic andn;
        logic xorrol;
    } ise_op_t;

    // 32-bit rotate left; s=0 is fine because a shift by 32 yields 0
    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] s);
        return (x << s) | (x >> (6'd32 - {1'b0, s}));
    endfunction

endpackage

// File: rtl/xoodyak_ise_lane.sv
// One 32-bit lane of the Xoodoo primitives; purely combinational.
module xoodyak_ise_lane
    import xalu_ise_pkg::*;
#(
    parameter bit EN_BASE = 1'b1,
    parameter bit EN_EXT  = 1'b1
) (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  ise_op_t     op_i,
    output logic [31:0] y_o
);

    // OR of the one-hot op terms; disabled ops are tied off so they synthesize away
    always_comb begin
        y_o = '0;
        if (EN_BASE && op_i.xorrol) y_o = y_o | (rol32(a_i, ROT_A) ^ rol32(b_i, ROT_B));
        if (EN_EXT  && op_i.andn)   y_o = y_o | (~a_i & b_i);
        if (EN_EXT  && op_i.rolv)   y_o = y_o | rol32(a_i, b_i[4:0]);
    end

endmodule

// File: rtl/xalu_ise_pipe.sv
// Pipelined lane-parallel Xoodyak ISE ALU with valid/ready, flush and
// a 1- or 2-stage register pipeline.
module xalu_ise_pipe
    import xalu_ise_pkg::*;
#(
    parameter int         XLEN   = 32,
    parameter logic [1:0] ISE_V  = 2'b11,
    parameter int         STAGES = 1
) (
    input  logic            ise_clk,
    input  logic            ise_rst,
    input  logic [5:0]      ise_fn,
    input  logic [6:0]      ise_imm,
    input  logic [XLEN-1:0] ise_in1,
    input  logic [XLEN-1:0] ise_in2,
    input  logic            ise_val,
    output logic            ise_rdy,
    input  logic            ise_flush,
    output logic            ise_oval,
    input  logic            ise_ordy,
    output logic [XLEN-1:0] ise_out,
    output logic            ise_sel
);

    localparam int NLANE = XLEN / 32;

    if ((XLEN != 32 && XLEN != 64) || (STAGES != 1 && STAGES != 2)) begin : g_bad_cfg
        $error("xalu_ise_pipe: unsupported XLEN/STAGES");
    end

    ise_op_t         dec_op;
    ise_op_t         lane_op;
    logic [XLEN-1:0] lane_a, lane_b, lane_y;
    logic [XLEN-1:0] res;
    logic            oval, v1_ld, accept, out_leave;
    logic            unused_fn;

    // Only fn[1:0] is decoded; upper selector bits are don't-care
    assign unused_fn = ^ise_fn[5:2];

    // Decode; ops disabled by ISE_V never produce a one-hot bit
    always_comb begin
        dec_op = '0;
        if (ise_fn[1:0] == CUSTOM_1) begin
            case (ise_imm)
                FN_XORROL: dec_op.xorrol = ISE_V[1];
                FN_ANDN:   dec_op.andn   = ISE_V[0];
                FN_ROLV:   dec_op.rolv   = ISE_V[0];
                default:   dec_op        = '0;
            endcase
        end
    end

    assign ise_sel   = |dec_op;
    assign ise_rdy   = ise_sel & v1_ld & ~ise_rst & ~ise_flush;
    assign accept    = ise_val & ise_rdy;
    assign out_leave = oval & ise_ordy;
    assign ise_oval  = oval;
    assign ise_out   = oval ? res : '0;

    for (genvar i = 0; i < NLANE; i++) begin : g_lane
        xoodyak_ise_lane #(
            .EN_BASE (ISE_V[1]),
            .EN_EXT  (ISE_V[0])
        ) u_lane (
            .a_i  (lane_a[32*i +: 32]),
            .b_i  (lane_b[32*i +: 32]),
            .op_i (lane_op),
            .y_o  (lane_y[32*i +: 32])
        );
    end

    if (STAGES == 1) begin : g_s1
        // Single stage: compute straight from the request, register the result
        logic            v1_q, v1_d;
        logic [XLEN-1:0] r1_q, r1_d;

        assign lane_a  = ise_in1;
        assign lane_b  = ise_in2;
        assign lane_op = dec_op;
        assign v1_ld   = ~v1_q | out_leave;
        assign oval    = v1_q;
        assign res     = r1_q;

        // Next-state: load when empty or draining; flush drops the valid bit
        always_comb begin
            v1_d = v1_q;
            r1_d = r1_q;
            if (v1_ld) begin
                v1_d = accept;
                if (accept) r1_d = lane_y;
            end
            if (ise_flush) v1_d = 1'b0;
        end

        // Stage register with synchronous reset
        always_ff @(posedge ise_clk) begin
            if (ise_rst) begin
                v1_q <= 1'b0;
                r1_q <= '0;
            end else begin
                v1_q <= v1_d;
                r1_q <= r1_d;
            end
        end
    end else begin : g_s2
        // Two stages: operands/op in stage 1, result in stage 2
        logic            v1_q, v1_d, v2_q, v2_d, s2_ld;
        logic [XLEN-1:0] a_q, a_d, b_q, b_d, r2_q, r2_d;
        ise_op_t         op_q, op_d;

        assign lane_a  = a_q;
        assign lane_b  = b_q;
        assign lane_op = op_q;
        assign s2_ld   = ~v2_q | out_leave;
        assign v1_ld   = ~v1_q | s2_ld;
        assign oval    = v2_q;
        assign res     = r2_q;

        // Next-state: each stage loads when empty or when its content moves on
        always_comb begin
            v1_d = v1_q;
            a_d  = a_q;
            b_d  = b_q;
            op_d = op_q;
            v2_d = v2_q;
            r2_d = r2_q;
            if (s2_ld) begin
                v2_d = v1_q;
                if (v1_q) r2_d = lane_y;
            end
            if (v1_ld) begin
                v1_d = accept;
                if (accept) begin
                    a_d  = ise_in1;
                    b_d  = ise_in2;
                    op_d = dec_op;
                end
            end
            if (ise_flush) begin
                v1_d = 1'b0;
                v2_d = 1'b0;
            end
        end

        // Stage registers with synchronous reset
        always_ff @(posedge ise_clk) begin
            if (ise_rst) begin
                v1_q <= 1'b0;
                a_q  <= '0;
                b_q  <= '0;
                op_q <= '0;
                v2_q <= 1'b0;
                r2_q <= '0;
            end else begin
                v1_q <= v1_d;
                a_q  <= a_d;
                b_q  <= b_d;
                op_q <= op_d;
                v2_q <= v2_d;
                r2_q <= r2_d;
            end
        end
    end

endmodule

// File: tb/tb_xalu_ise_pipe.sv
// Scoreboard bench for xalu_ise_pipe: main DUT is XLEN=64/STAGES=2/full ISE,
// a side instance is XLEN=32/STAGES=1/base set only.
module tb_xalu_ise_pipe;

    localparam logic [6:0] F_XR = 7'h20;
    localparam logic [6:0] F_AN = 7'h21;
    localparam logic [6:0] F_RV = 7'h22;

    logic        clk;
    logic        rst, flush, val, ordy_man, ordy_rnd, rand_ordy;
    logic        ordy;
    logic [5:0]  fn;
    logic [6:0]  imm;
    logic [63:0] in1, in2;
    logic        rdy, oval, sel;
    logic [63:0] out;
    logic        ob_rdy, ob_oval, ob_sel;
    logic [31:0] ob_out;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] q[$];

    assign ordy = rand_ordy ? ordy_rnd : ordy_man;

    xalu_ise_pipe #(.XLEN(64), .ISE_V(2'b11), .STAGES(2)) dut (
        .ise_clk(clk), .ise_rst(rst), .ise_fn(fn), .ise_imm(imm),
        .ise_in1(in1), .ise_in2(in2), .ise_val(val), .ise_rdy(rdy),
        .ise_flush(flush), .ise_oval(oval), .ise_ordy(ordy),
        .ise_out(out), .ise_sel(sel)
    );

    xalu_ise_pipe #(.XLEN(32), .ISE_V(2'b10), .STAGES(1)) u_b (
        .ise_clk(clk), .ise_rst(rst), .ise_fn(fn), .ise_imm(imm),
        .ise_in1(in1[31:0]), .ise_in2(in2[31:0]), .ise_val(val), .ise_rdy(ob_rdy),
        .ise_flush(flush), .ise_oval(ob_oval), .ise_ordy(1'b1),
        .ise_out(ob_out), .ise_sel(ob_sel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        #1 ordy_rnd = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
        int k;
        k = s % 32;
        if (k == 0) return x;
        return (x << k) | (x >> (32 - k));
    endfunction

    // op: 0=XORROL 1=ANDN 2=ROLV, applied to each 32-bit half separately
    function automatic logic [63:0] ref_model(input int op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        logic [31:0] x, y;
        r = '0;
        for (int i = 0; i < 2; i++) begin
            x = a[32*i +: 32];
            y = b[32*i +: 32];
            case (op)
                0:       r[32*i +: 32] = rotl(x, 5) ^ rotl(y, 14);
                1:       r[32*i +: 32] = ~x & y;
                default: r[32*i +: 32] = rotl(x, int'(y % 32));
            endcase
        end
        return r;
    endfunction

    // Drive one request; legal ones wait for acceptance and push the expectation
    task automatic issue(input logic [5:0] f, input logic [6:0] im, input logic [63:0] a,
                         input logic [63:0] b, input logic legal, input logic [63:0] exp,
                         output int waits);
        logic acc;
        logic bsel;
        waits = 0;
        acc   = 1'b0;
        bsel  = (f[1:0] == 2'b01) && (im == F_XR);
        fn = f; imm = im; in1 = a; in2 = b; val = 1'b1;
        @(negedge clk);
        chk("sel", {63'd0, sel}, {63'd0, legal});
        chk("b_sel", {63'd0, ob_sel}, {63'd0, bsel});
        chk("b_rdy", {63'd0, ob_rdy}, {63'd0, bsel});
        if (!legal) begin
            chk("rdy_illegal", {63'd0, rdy}, 64'd0);
        end else begin
            while (!rdy && waits < 200) begin
                @(negedge clk);
                waits++;
            end
            acc = rdy;
            if (!acc) chk("accept_timeout", {63'd0, rdy}, 64'd1);
        end
        @(posedge clk);
        if (acc) q.push_back(exp);
        #1 val = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        ordy_man  = 1'b1;
        rand_ordy = 1'b0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", 64'(q.size()), 64'd0);
        q.delete();
        #1;
    endtask

    // Monitor: pop on every consumed result, check hold under stall and zero-when-idle
    initial begin
        logic        stall_prev;
        logic [63:0] prev_out, e;
        stall_prev = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge clk);
            if (stall_prev) begin
                chk("hold_valid", {63'd0, oval}, 64'd1);
                chk("hold_data", out, prev_out);
            end
            if (!oval) begin
                chk("idle_zero", out, 64'd0);
            end else if (ordy) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got %h expected none at %0t", out, $time);
                end else begin
                    e = q.pop_front();
                    chk("result", out, e);
                end
            end
            stall_prev = oval & ~ordy & ~rst & ~flush;
            prev_out   = out;
        end
    end

    initial begin
        int          w;
        logic [63:0] a, b;
        rst = 1'b1; flush = 1'b0; val = 1'b1; fn = 6'b000001; imm = F_XR;
        in1 = 64'd1; in2 = 64'd1; ordy_man = 1'b1; rand_ordy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", {63'd0, rdy}, 64'd0);
        chk("rst_oval", {63'd0, oval}, 64'd0);
        chk("rst_out", out, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0; val = 1'b0;

        // First XORROL(1,1): lane0 0x4020, lane1 0
        issue(6'b000001, F_XR, 64'd1, 64'd1, 1'b1, 64'h0000_0000_0000_4020, w);
        @(negedge clk);
        chk("b_oval", {63'd0, ob_oval}, 64'd1);
        chk("b_out", {32'd0, ob_out}, 64'h4020);
        chk("lat_c1", {63'd0, oval}, 64'd0);
        @(negedge clk);
        chk("lat_c2", {63'd0, oval}, 64'd1);
        chk("b_idle", {63'd0, ob_oval}, 64'd0);
        @(posedge clk); #1;

        // Unknown funct and wrong custom slot
        issue(6'b000001, 7'h7F, 64'd5, 64'd6, 1'b0, 64'd0, w);
        issue(6'b000000, F_XR, 64'd5, 64'd6, 1'b0, 64'd0, w);
        issue(6'b111101, F_XR, 64'd1, 64'd1, 1'b1, 64'h0000_0000_0000_4020, w);

        // Lane independence on 64-bit
        issue(6'b000001, F_RV, 64'h80000000_00000001, 64'h00000001_00000004, 1'b1,
              64'h00000001_00000010, w);
        issue(6'b000001, F_AN, 64'hFFFF0000_FFFF0000, 64'hFFFFFFFF_FFFFFFFF, 1'b1,
              64'h0000FFFF_0000FFFF, w);
        issue(6'b000001, F_RV, 64'h12345678_9ABCDEF0, 64'h0000001F_00000000, 1'b1,
              64'h091A2B3C_9ABCDEF0, w);
        drain();

        // Back-to-back XORROL with ordy=1: never stalls
        for (int k = 0; k < 8; k++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            issue(6'b000001, F_XR, a, b, 1'b1, ref_model(0, a, b), w);
            chk("stream_nobubble", 64'(w), 64'd0);
        end
        // Same with random backpressure
        rand_ordy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            issue(6'b000001, F_XR, a, b, 1'b1, ref_model(0, a, b), w);
        end
        // Random mix including illegal requests
        for (int k = 0; k < 60; k++) begin
            int          op, pick;
            logic [5:0]  f;
            logic [6:0]  im;
            logic        lg;
            a  = {$urandom, $urandom}; b = {$urandom, $urandom};
            op = $urandom_range(0, 2);
            f  = {4'($urandom), 2'b01};
            im = F_XR + 7'(op);
            lg = 1'b1;
            pick = $urandom_range(0, 7);
            if (pick == 0) begin
                im = 7'($urandom);
                if (im >= F_XR && im <= F_RV) im = 7'h7F;
                lg = 1'b0;
            end else if (pick == 1) begin
                f[1:0] = 2'($urandom_range(0, 2));
                if (f[1:0] == 2'b01) f[1:0] = 2'b11;
                lg = 1'b0;
            end
            issue(f, im, a, b, lg, ref_model(op, a, b), w);
        end
        drain();

        // Full pipe: stall then same-cycle accept when ordy rises
        ordy_man = 1'b0;
        issue(6'b000001, F_AN, 64'h1111, 64'hFFFF, 1'b1, 64'h0000_0000_0000_EEEE, w);
        issue(6'b000001, F_XR, 64'd1, 64'd1, 1'b1, 64'h0000_0000_0000_4020, w);
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        fn = 6'b000001; imm = F_RV; in1 = a; in2 = b; val = 1'b1;
        @(negedge clk);
        chk("full_rdy", {63'd0, rdy}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("full_rdy_hold", {63'd0, rdy}, 64'd0);
        @(posedge clk);
        #1 ordy_man = 1'b1;
        @(negedge clk);
        chk("full_rdy_up", {63'd0, rdy}, 64'd1);
        @(posedge clk);
        q.push_back(ref_model(2, a, b));
        #1 val = 1'b0;
        drain();

        // Flush with two results in flight, ordy low: nothing consumed
        ordy_man = 1'b0;
        issue(6'b000001, F_XR, 64'hAAAA, 64'h5555, 1'b1, ref_model(0, 64'hAAAA, 64'h5555), w);
        issue(6'b000001, F_XR, 64'h1234, 64'h4321, 1'b1, ref_model(0, 64'h1234, 64'h4321), w);
        fn = 6'b000001; imm = F_XR; val = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("flush_rdy", {63'd0, rdy}, 64'd0);
        @(posedge clk);
        q.delete();
        #1 flush = 1'b0; val = 1'b0; ordy_man = 1'b1;
        @(negedge clk);
        chk("flush_clr1", {63'd0, oval}, 64'd0);
        @(negedge clk);
        chk("flush_clr2", {63'd0, oval}, 64'd0);
        @(posedge clk); #1;
        issue(6'b000001, F_AN, 64'h0F0F, 64'hFFFF, 1'b1, 64'h0000_0000_0000_F0F0, w);
        @(negedge clk);
        chk("flush_lat_c1", {63'd0, oval}, 64'd0);
        @(negedge clk);
        chk("flush_lat_c2", {63'd0, oval}, 64'd1);
        @(posedge clk); #1;
        drain();

        // Reset mid-stream with ordy high: head consumed, rest discarded
        ordy_man = 1'b0;
        issue(6'b000001, F_XR, 64'h77, 64'h88, 1'b1, ref_model(0, 64'h77, 64'h88), w);
        issue(6'b000001, F_RV, 64'h99, 64'h3, 1'b1, ref_model(2, 64'h99, 64'h3), w);
        ordy_man = 1'b1; rst = 1'b1; val = 1'b1; imm = F_XR;
        @(negedge clk);
        chk("rst_mid_rdy", {63'd0, rdy}, 64'd0);
        @(posedge clk);
        q.delete();
        #1 rst = 1'b0; val = 1'b0;
        @(negedge clk);
        chk("rst_mid_oval", {63'd0, oval}, 64'd0);
        chk("rst_mid_out", out, 64'd0);
        @(posedge clk); #1;
        issue(6'b000001, F_XR, 64'd1, 64'd1, 1'b1, 64'h0000_0000_0000_4020, w);
        @(negedge clk);
        chk("rst_lat_c1", {63'd0, oval}, 64'd0);
        @(negedge clk);
        chk("rst_lat_c2", {63'd0, oval}, 64'd1);
        @(posedge clk); #1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xalu_ise_pipe.md
# xalu_ise_pipe

Pipelined, parametrised Xoodyak ISE ALU for the RV32/RV64 cores. It accepts decoded custom-opcode requests from the core's execute stage and applies the Xoodoo round primitives to every 32-bit lane of the operands. Requests and results use a valid/ready handshake, and results return after a fixed, parametrised latency. The block replaces the single-cycle combinational ISE ALU and adds lane-parallel 64-bit operation, extra primitives, backpressure and flush.

## Interface
- XLEN, 32: datapath width; 32 or 64. NLANE = XLEN/32 independent 32-bit lanes.
- ISE_V, 2'b11: bit1 enables the base set (XORROL); bit0 enables the extended set (ANDN, ROLV). A cleared bit means the op is never selected.
- STAGES, 1: pipeline depth; 1 or 2. Any other value is an elaboration error.
- ise_clk  in  1  clock; everything is rising-edge.
- ise_rst  in  1  synchronous, active-high reset.
- ise_fn  in  6  custom-opcode selector; only [1:0] is decoded (CUSTOM_0..3 = 00..11).
- ise_imm  in  7  funct7.
- ise_in1  in  XLEN  rs1.
- ise_in2  in  XLEN  rs2.
- ise_val  in  1  request valid.
- ise_rdy  out  1  request ready. It is qualified by the request: it is high only for a selected op with pipeline space.
- ise_flush  in  1  discards all in-flight results.
- ise_oval  out  1  result valid.
- ise_ordy  in  1  consumer ready.
- ise_out  out  XLEN  result; 0 whenever ise_oval=0.
- ise_sel  out  1  combinational "op is ISE" flag, so the core can route unselected ops elsewhere.

## Operation
- Decode (all ops require ise_fn[1:0]=CUSTOM_1):
  - funct 0100000 = XORROL (needs ISE_V[1]).
  - funct 0100001 = ANDN (needs ISE_V[0]).
  - funct 0100010 = ROLV (needs ISE_V[0]).
  - Anything else: ise_sel=0 and ise_rdy=0; the request is never accepted and never produces ise_oval.
- Per lane i (bits 32i+31:32i), with a=rs1 lane and b=rs2 lane:
  - XORROL: rol(a,5) ^ rol(b,14).
  - ANDN: ~a & b.
  - ROLV: rol(a, b[4:0]), with a per-lane rotate amount.
- Lanes never interact; there is no carry or rotate across the lane boundary.
- Accept condition: ise_val & ise_sel & ise_rdy. On accept, operands and a one-hot op are captured into stage 1.
- STAGES=1: the stage-1 register holds the computed result, and ise_oval = v1.
- STAGES=2: stage 1 holds operands and op; stage 2 holds the result. ise_oval = v2.
- Advance rule for each stage: it loads when it is empty or when its content leaves in the same cycle. Output leaves on ise_oval & ise_ordy.
- ise_rdy = ise_sel & (!v1 | v1 leaving this cycle) & !ise_rst & !ise_flush.
- Flush: all valid bits clear on the next edge. A request presented in the flush cycle is not accepted.
- Reset: all valid bits are 0, data registers are 0, and ise_out is 0. Reset takes precedence over flush and accept.

## Timing
- Latency from accepting edge to ise_oval high is STAGES cycles. Throughput is 1 result per cycle while ise_ordy=1.
- While ise_oval=1 and ise_ordy=0, ise_out and ise_oval hold stable. Upstream stalls once every stage is full. No result is dropped or duplicated.
- Simultaneous output and accept into a full pipe proceeds with no bubble.
- Reset or flush asserted mid-stream:
  - Nothing is valid on the following cycle.
  - Results already on ise_out in that cycle still count as consumed only if ise_ordy=1 in that same cycle.
- The ise_sel path is combinational from ise_fn/ise_imm. The ise_rdy path is combinational from ise_ordy; there is no combinational path from ise_in* to outputs.

## Structure
- Package xalu_ise_pkg holds:
  - CUSTOM_0..3 constants;
  - funct7 codes FN_XORROL / FN_ANDN / FN_ROLV;
  - the one-hot op typedef (3 bits);
  - ROT_A=5 and ROT_B=14.
- Sub-module xoodyak_ise_lane: combinational 32-bit lane datapath with inputs a, b and the one-hot op. It is instantiated NLANE times in a generate loop, and is gated per op by the ISE_V enables.
- The top level contains decode, the valid/ready pipeline control and the stage registers.

## Test plan
- XLEN=32, STAGES=1, XORROL with in1=0x00000001, in2=0x00000001:
  - Accepted, then 1 cycle later ise_oval=1 and ise_out=0x00004020.
  - Unknown funct 0x7F gives ise_sel=0, ise_rdy=0 and no ise_oval.
- XLEN=64, ROLV with in1=0x80000000_00000001, in2=0x00000001_00000004:
  - ise_out=0x00000001_00000010; lanes are independent.
  - ANDN with in1=0xFFFF0000_FFFF0000 and in2 all ones gives ise_out=0x0000FFFF_0000FFFF.
- STAGES=2, back-to-back stream of 8 XORROL requests, ise_ordy=1:
  - First result at cycle 2, then one per cycle, in order.
  - Toggle ise_ordy 0/1 randomly: all 8 results arrive in order, with ise_out stable while stalled.
- Pipe full with ise_ordy=0: ise_rdy=0 and the request is held. Raising ise_ordy gives a same-cycle accept with no bubble.
- Flush with 2 results in flight: no ise_oval on following cycles, and the next request after flush has normal latency.
  - Reset asserted mid-stream gives the same behaviour, and ise_out=0 afterwards.
- ISE_V=2'b10: ANDN and ROLV are never selected or accepted, while XORROL is unaffected.
